// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions.
//   - NR: number of AES-128 rounds.
//   - state_t: 128-bit cipher state, FIPS-197 byte 0 in bits [127:120].
//   - bytes_t: the same state viewed as 16 bytes, index 0 = byte 0.
//   - fsm_state_e: iterative core FSM states.
//   - xtime / gf_mul / gf_inv: GF(2^8) arithmetic, polynomial 0x11b.
//   - sbox / inv_sbox: S-box computed from the field inverse and affine map.
//   - rpc_legal: legal values of ROUNDS_PER_CYCLE.
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0]       state_t;
    typedef logic [0:15][7:0]   bytes_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] base;
        acc  = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            acc  = gf_mul(acc, base);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    // Undo the affine map first, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic bit rpc_legal(input int n);
        return (n == 1) || (n == 2) || (n == 5) || (n == 10);
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// aes_round_unit: one combinational AES round.
//   state_in    : state entering the round.
//   round_key   : key to add (rk[j] for encrypt, rk[10-j] for decrypt).
//   decrypt     : 1 selects the straight inverse round.
//   final_round : 1 skips (Inv)MixColumns.
//   state_out   : state leaving the round.
// Encrypt: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// Decrypt: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_round_unit
    import aes_pkg::*;
#(
    parameter bit ENABLE_DECRYPT = 1'b1
) (
    input  state_t state_in,
    input  state_t round_key,
    input  logic   decrypt,
    input  logic   final_round,
    output state_t state_out
);

    bytes_t s;
    bytes_t k;
    bytes_t enc_sr;
    bytes_t enc_mc;
    bytes_t enc_out;

    assign s = state_in;
    assign k = round_key;

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        enc_sr = '0;
        enc_mc = '0;
        // Byte index is row + 4*column; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                enc_sr[r+4*c] = sbox(s[r+4*((c+r)%4)]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = enc_sr[4*c];
            a1 = enc_sr[4*c+1];
            a2 = enc_sr[4*c+2];
            a3 = enc_sr[4*c+3];
            enc_mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            enc_mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            enc_mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            enc_mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        enc_out = (final_round ? enc_sr : enc_mc) ^ k;
    end

    if (ENABLE_DECRYPT) begin : g_dec
        bytes_t dec_ark;
        bytes_t dec_imc;

        always_comb begin
            logic [7:0] a0, a1, a2, a3;
            dec_ark = '0;
            dec_imc = '0;
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    dec_ark[r+4*c] = inv_sbox(s[r+4*((c-r+4)%4)]) ^ k[r+4*c];
                end
            end
            for (int c = 0; c < 4; c++) begin
                a0 = dec_ark[4*c];
                a1 = dec_ark[4*c+1];
                a2 = dec_ark[4*c+2];
                a3 = dec_ark[4*c+3];
                dec_imc[4*c]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
                dec_imc[4*c+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
                dec_imc[4*c+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
                dec_imc[4*c+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
            end
        end

        assign state_out = decrypt ? (final_round ? dec_ark : dec_imc) : enc_out;
    end else begin : g_enc_only
        logic unused_decrypt;
        assign unused_decrypt = decrypt;
        assign state_out      = enc_out;
    end

endmodule

// File: rtl/key_expansion.sv
// key_expansion: combinational AES-128 key schedule.
//   key_in     : 128-bit cipher key, byte 0 in MSBs.
//   round_keys : rk[0..10], round_keys[0] equals key_in.
module key_expansion
    import aes_pkg::*;
(
    input  state_t                key_in,
    output logic [0:NR][127:0]    round_keys
);

    always_comb begin
        logic [31:0] w [0:4*NR+3];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key_in[127-32*i -: 32];
        for (int i = 4; i < 4*NR+4; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                // RotWord, SubWord, then Rcon on the leading byte.
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])}
                    ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) begin
            round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end

endmodule

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encrypt/decrypt core.
//   clk, rst             : rising-edge clock, synchronous active-high reset.
//   key_in, key_we       : key load, honoured only in IDLE; key_ok flags a loaded schedule.
//   in_valid/in_ready    : input block handshake, in_data + in_decrypt sampled together.
//   out_valid/out_ready  : result handshake, out_data + out_decrypt held while stalled.
//   busy                 : FSM is not in IDLE.
// ROUNDS_PER_CYCLE chained round units cover the 10 rounds in 10/ROUNDS_PER_CYCLE cycles.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// A producer keeps valid and its payload stable until that edge; ready never
// depends on valid. in_ready is low while key_we is high, so a key load always
// wins over a block in the same cycle. No block is accepted in DONE.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit ENABLE_DECRYPT   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_we,
    output logic         key_ok,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_decrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_decrypt,
    output logic         busy
);

    if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    // Round counter value at the start of the last chunk.
    localparam logic [3:0] LAST_R = 4'(NR - ROUNDS_PER_CYCLE + 1);

    fsm_state_e         state;
    state_t             st;
    logic [3:0]         r;
    logic               mode;
    logic [0:NR][127:0] rk;
    logic [0:NR][127:0] rk_exp;
    logic               dec_in;
    state_t             chain [0:ROUNDS_PER_CYCLE];

    key_expansion u_key_expansion (
        .key_in     (key_in),
        .round_keys (rk_exp)
    );

    assign dec_in   = ENABLE_DECRYPT && in_decrypt;
    assign in_ready = (state == IDLE) && key_ok && !key_we;
    assign busy     = (state != IDLE);
    assign chain[0] = st;

    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        logic [4:0] j;
        logic [3:0] kidx;

        assign j = {1'b0, r} + 5'(k);

        // Outside RUN, j may exceed 10; clamp the key index so the mux stays in range.
        always_comb begin
            kidx = 4'd0;
            if (j <= 5'(NR)) kidx = mode ? 4'(NR - int'(j)) : j[3:0];
        end

        aes_round_unit #(
            .ENABLE_DECRYPT (ENABLE_DECRYPT)
        ) u_round (
            .state_in    (chain[k]),
            .round_key   (rk[kidx]),
            .decrypt     (mode),
            .final_round (j == 5'(NR)),
            .state_out   (chain[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            st          <= '0;
            r           <= '0;
            mode        <= 1'b0;
            rk          <= '0;
            key_ok      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_decrypt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_we) begin
                        rk     <= rk_exp;
                        key_ok <= 1'b1;
                    end else if (in_valid && in_ready) begin
                        st    <= in_data ^ (dec_in ? rk[NR] : rk[0]);
                        r     <= 4'd1;
                        mode  <= dec_in;
                        state <= RUN;
                    end
                end
                RUN: begin
                    st <= chain[ROUNDS_PER_CYCLE];
                    r  <= r + 4'(ROUNDS_PER_CYCLE);
                    if (r == LAST_R) begin
                        out_data    <= chain[ROUNDS_PER_CYCLE];
                        out_decrypt <= mode;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core: four cores (ROUNDS_PER_CYCLE = 1, 2, 5, 10) driven
// independently from one clock, checked against a byte-level AES model.
module tb_aes128_iter_core;

    localparam int NDUT = 4;
    localparam int RPC_TAB [NDUT] = '{1, 2, 5, 10};

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst         [NDUT];
    logic [127:0] key_in      [NDUT];
    logic         key_we      [NDUT];
    logic         key_ok      [NDUT];
    logic         in_valid    [NDUT];
    logic         in_ready    [NDUT];
    logic [127:0] in_data     [NDUT];
    logic         in_decrypt  [NDUT];
    logic         out_valid   [NDUT];
    logic         out_ready   [NDUT];
    logic [127:0] out_data    [NDUT];
    logic         out_decrypt [NDUT];
    logic         busy        [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes128_iter_core #(
            .ROUNDS_PER_CYCLE (RPC_TAB[g]),
            .ENABLE_DECRYPT   (1'b1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .key_in      (key_in[g]),
            .key_we      (key_we[g]),
            .key_ok      (key_ok[g]),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_data     (in_data[g]),
            .in_decrypt  (in_decrypt[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_data    (out_data[g]),
            .out_decrypt (out_decrypt[g]),
            .busy        (busy[g])
        );
    end

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [128:0] exp_q [$];
    logic [127:0] cur_key [NDUT];

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    // Carry-less product then reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, o, c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[a]  = o;
            isb[o] = 8'(a);
        end
    endtask

    function automatic logic [127:0] m_sub(input logic [127:0] x, input bit inv);
        logic [0:15][7:0] b;
        b = x;
        for (int i = 0; i < 16; i++) b[i] = inv ? isb[b[i]] : sb[b[i]];
        return b;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] x);
        logic [0:15][7:0] b, o;
        b = x;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[r+4*c] = b[r+4*((c+r)%4)];
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] x);
        logic [0:15][7:0] a, o;
        a = x;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[4*c+r] = gmul(8'h02, a[4*c+r]) ^ gmul(8'h03, a[4*c+(r+1)%4])
                         ^ a[4*c+(r+2)%4] ^ a[4*c+(r+3)%4];
        return o;
    endfunction

    function automatic logic [127:0] m_rk(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] m_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ m_rk(key, 0);
        for (int j = 1; j <= 10; j++) begin
            s = m_shift(m_sub(s, 1'b0));
            if (j < 10) s = m_mix(s);
            s = s ^ m_rk(key, j);
        end
        return s;
    endfunction

    // Inverse ShiftRows = ShiftRows three times; inverse MixColumns = MixColumns three times.
    function automatic logic [127:0] m_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ m_rk(key, 10);
        for (int j = 1; j <= 10; j++) begin
            s = m_sub(m_shift(m_shift(m_shift(s))), 1'b1);
            s = s ^ m_rk(key, 10 - j);
            if (j < 10) s = m_mix(m_mix(m_mix(s)));
        end
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int d, input logic [127:0] key);
        key_in[d]   = key;
        key_we[d]   = 1'b1;
        in_valid[d] = 1'b1;
        in_data[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        check($sformatf("d%0d_ready_low_on_key_we", d), 160'(in_ready[d]), 160'(0));
        tick();
        key_we[d]   = 1'b0;
        in_valid[d] = 1'b0;
        check($sformatf("d%0d_key_ok", d), 160'(key_ok[d]), 160'(1));
        check($sformatf("d%0d_no_accept_with_key_we", d), 160'(busy[d]), 160'(0));
        #1;
        check($sformatf("d%0d_ready_after_key", d), 160'(in_ready[d]), 160'(1));
        cur_key[d] = key;
    endtask

    task automatic send(input int d, input logic [127:0] data, input logic dec, input logic [128:0] exp);
        int n;
        n = 0;
        while (!in_ready[d] && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("d%0d_in_ready_wait", d), 160'(in_ready[d]), 160'(1));
        in_valid[d]   = 1'b1;
        in_data[d]    = data;
        in_decrypt[d] = dec;
        tick();
        in_valid[d] = 1'b0;
        check($sformatf("d%0d_busy_after_accept", d), 160'(busy[d]), 160'(1));
        exp_q.push_back(exp);
    endtask

    task automatic receive(input int d, input int lat_exp, input int hold, input bit chk_lat);
        int           lat;
        logic [128:0] exp, got;
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            tick();
            lat++;
        end
        exp = exp_q.pop_front();
        if (!out_valid[d]) begin
            check($sformatf("d%0d_out_valid_timeout", d), 160'(out_valid[d]), 160'(1));
            return;
        end
        if (chk_lat) check($sformatf("d%0d_latency", d), 160'(lat), 160'(lat_exp));
        got = {out_decrypt[d], out_data[d]};
        check($sformatf("d%0d_result", d), 160'(got), 160'(exp));
        for (int h = 0; h < hold; h++) begin
            tick();
            check($sformatf("d%0d_hold_data", d), 160'({out_decrypt[d], out_data[d]}), 160'(exp));
            check($sformatf("d%0d_hold_valid", d), 160'(out_valid[d]), 160'(1));
            check($sformatf("d%0d_hold_in_ready", d), 160'(in_ready[d]), 160'(0));
            check($sformatf("d%0d_hold_busy", d), 160'(busy[d]), 160'(1));
        end
        // Offer a new block during the output handshake: DONE must not take it.
        out_ready[d]  = 1'b1;
        in_valid[d]   = 1'b1;
        in_data[d]    = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_decrypt[d] = 1'b0;
        tick();
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        check($sformatf("d%0d_valid_drop", d), 160'(out_valid[d]), 160'(0));
        check($sformatf("d%0d_no_accept_in_done", d), 160'(busy[d]), 160'(0));
        #1;
        check($sformatf("d%0d_ready_after_out", d), 160'(in_ready[d]), 160'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] data, key2;
        logic         dec;
        int           lat;

        for (int d = 0; d < NDUT; d++) begin
            rst[d]        = 1'b1;
            key_in[d]     = '0;
            key_we[d]     = 1'b0;
            in_valid[d]   = 1'b0;
            in_data[d]    = '0;
            in_decrypt[d] = 1'b0;
            out_ready[d]  = 1'b0;
            cur_key[d]    = '0;
        end
        build_tables();
        tick();
        tick();
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        #1;

        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_rst_out_valid", d), 160'(out_valid[d]), 160'(0));
            check($sformatf("d%0d_rst_busy", d), 160'(busy[d]), 160'(0));
            check($sformatf("d%0d_rst_key_ok", d), 160'(key_ok[d]), 160'(0));
            check($sformatf("d%0d_rst_in_ready", d), 160'(in_ready[d]), 160'(0));
            check($sformatf("d%0d_rst_out", d), 160'({out_decrypt[d], out_data[d]}), 160'(0));
        end

        // No key loaded: a valid block must be refused.
        in_valid[0] = 1'b1;
        in_data[0]  = PT_B;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("nokey_in_ready", 160'(in_ready[0]), 160'(0));
            check("nokey_busy", 160'(busy[0]), 160'(0));
            check("nokey_out_valid", 160'(out_valid[0]), 160'(0));
        end
        in_valid[0] = 1'b0;

        // FIPS-197 known answers on every configuration.
        for (int d = 0; d < NDUT; d++) begin
            lat = 10 / RPC_TAB[d];
            load_key(d, KEY_B);
            send(d, PT_B, 1'b0, {1'b0, CT_B});
            receive(d, lat, 0, 1'b1);
            load_key(d, KEY_C);
            send(d, CT_C, 1'b1, {1'b1, PT_C});
            receive(d, lat, 0, 1'b1);
            send(d, PT_C, 1'b0, {1'b0, CT_C});
            receive(d, lat, 1, 1'b1);
        end

        // Backpressure: six stalled cycles.
        load_key(0, KEY_B);
        send(0, PT_B, 1'b0, {1'b0, CT_B});
        receive(0, 10, 6, 1'b1);

        // key_we (and a stray out_ready) mid-RUN are ignored.
        send(0, PT_B, 1'b0, {1'b0, CT_B});
        tick();
        tick();
        tick();
        key2         = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_in[0]    = key2;
        key_we[0]    = 1'b1;
        out_ready[0] = 1'b1;
        tick();
        key_we[0]    = 1'b0;
        out_ready[0] = 1'b0;
        check("midrun_busy", 160'(busy[0]), 160'(1));
        check("midrun_key_ok", 160'(key_ok[0]), 160'(1));
        receive(0, 0, 0, 1'b0);
        load_key(0, key2);
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data, 1'b0, {1'b0, m_enc(key2, data)});
        receive(0, 10, 0, 1'b1);

        // Reset four cycles into RUN.
        send(0, PT_B, 1'b0, {1'b0, CT_B});
        void'(exp_q.pop_back());
        tick();
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("midrst_out_valid", 160'(out_valid[0]), 160'(0));
        check("midrst_busy", 160'(busy[0]), 160'(0));
        check("midrst_key_ok", 160'(key_ok[0]), 160'(0));
        check("midrst_in_ready", 160'(in_ready[0]), 160'(0));
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_result", 160'(out_valid[0]), 160'(0));
        end
        load_key(0, KEY_B);
        send(0, PT_B, 1'b0, {1'b0, CT_B});
        receive(0, 10, 0, 1'b1);

        // Randomized blocks against the model.
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 6; k++) begin
                if (k % 3 == 0) load_key(d, {$urandom(), $urandom(), $urandom(), $urandom()});
                data = {$urandom(), $urandom(), $urandom(), $urandom()};
                dec  = 1'($urandom_range(1, 0));
                send(d, data, dec, {dec, dec ? m_dec(cur_key[d], data) : m_enc(cur_key[d], data)});
                receive(d, 10 / RPC_TAB[d], $urandom_range(3, 0), 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
